// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: key/data load and result bus between loaders, sequencer and consumer
//   Kin/Krdy : cipher key (byte 0 at [127:120]) and key-load strobe
//   Din/Drdy : plaintext block and data-load strobe
//   Dout/Dvld: ciphertext block and its one-cycle valid pulse
//   Kvld     : one-cycle key-accepted pulse
//   BSY      : block in flight
interface aes_round_ctrl_if;
  logic [127:0] Kin;
  logic         Krdy;
  logic [127:0] Din;
  logic         Drdy;
  logic [127:0] Dout;
  logic         Dvld;
  logic         Kvld;
  logic         BSY;
  modport master (output Kin, Krdy, Din, Drdy, input Dout, Dvld, Kvld, BSY);
  modport slave  (input Kin, Krdy, Din, Drdy, output Dout, Dvld, Kvld, BSY);
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer, one round per clock
//   CLK  : system clock, rising edge
//   RSTn : asynchronous active-low reset
//   bus  : aes_round_ctrl_if.slave (Kin/Krdy, Din/Drdy in; Dout/Dvld/Kvld/BSY out)
//   AES_CTRL_MASK_DOUT_EN: when defined, Dout reads zero outside the Dvld cycle
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input logic CLK,
  input logic RSTn,
  aes_round_ctrl_if.slave bus
);
  typedef enum logic [1:0] {NOKEY, IDLE, RUN} state_t;
  state_t st, st_n;
  logic [127:0] k0, state, rk, rk_n, nxt, dout;
  logic [7:0] rcon;
  logic [3:0] rnd;
  logic dvld, kvld, bsy, load_k, load_d, done;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      r = b[i] ? r ^ x : r;
      x = xt(x);
    end
    return r;
  endfunction
  // S-box as GF(2^8) inverse (a^254, square-and-multiply) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] keyexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  // One cipher round; byte i = row i%4, column i/4. last skips MixColumns.
  function automatic logic [127:0] aes_core(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      o[127-32*c -: 32] = last ? {a0, a1, a2, a3} :
        {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
         a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
         a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
         xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ k;
  endfunction
  assign rk_n = keyexp(rk, rcon);
  assign nxt = aes_core(state, rk_n, rnd == 4'(NR));
  always_comb begin
    load_k = st != RUN && bus.Krdy;
    load_d = st == IDLE && bus.Drdy && !bus.Krdy;
    done = st == RUN && rnd == 4'(NR);
    st_n = load_k ? IDLE : load_d ? RUN : done ? IDLE : st;
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) st <= NOKEY;
    else st <= st_n;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      k0 <= '0;
      state <= '0;
      rk <= '0;
      rcon <= 8'h01;
      rnd <= '0;
      dout <= '0;
      dvld <= 1'b0;
      kvld <= 1'b0;
      bsy <= 1'b0;
    end else begin
      kvld <= load_k;
      dvld <= done;
      if (load_k) k0 <= bus.Kin;
      if (load_d) begin
        state <= bus.Din ^ k0;
        rk <= k0;
        rcon <= 8'h01;
        rnd <= 4'd1;
        bsy <= 1'b1;
      end else if (st == RUN) begin
        state <= nxt;
        rk <= rk_n;
        rcon <= xt(rcon);
        rnd <= done ? 4'd0 : rnd + 4'd1;
        bsy <= !done;
      end
      if (done) dout <= nxt;
`ifdef AES_CTRL_MASK_DOUT_EN
      else if (dvld) dout <= '0;
`endif
    end
`ifdef AES_CTRL_MASK_DOUT_EN
  assign bus.Dout = dvld ? dout : '0;
`else
  assign bus.Dout = dout;
`endif
  assign bus.Dvld = dvld;
  assign bus.Kvld = kvld;
  assign bus.BSY = bsy;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed FIPS-197 vectors and control corner cases for aes_round_ctrl
module tb_aes_round_ctrl;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] D2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  aes_round_ctrl_if bus ();
  aes_round_ctrl dut (.CLK(clk), .RSTn(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  // Accepts din at the next edge, optionally pokes Krdy/Drdy mid-run, and stops in the Dvld cycle.
  task automatic run_block(input string tag, input logic [127:0] din, input logic [127:0] exp, input logic poke);
    int lat;
    logic kv;
    bus.Din = din;
    bus.Drdy = 1'b1;
    tick();
    bus.Drdy = 1'b0;
    chk({tag, "_bsy"}, 128'(bus.BSY), 128'(1));
`ifdef AES_CTRL_MASK_DOUT_EN
    chk({tag, "_dout_masked_before"}, bus.Dout, '0);
`endif
    lat = 1;
    kv = 1'b0;
    while (!bus.Dvld && lat < 30) begin
      if (poke && lat == 3) begin
        bus.Kin = K1;
        bus.Krdy = 1'b1;
        bus.Din = D1;
        bus.Drdy = 1'b1;
      end
      tick();
      bus.Krdy = 1'b0;
      bus.Drdy = 1'b0;
      kv |= bus.Kvld;
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(11));
    chk({tag, "_dout"}, bus.Dout, exp);
    if (poke) chk({tag, "_kvld_ignored"}, 128'(kv), 128'(0));
  endtask
  initial begin
    logic busy_seen;
    bus.Kin = '0;
    bus.Krdy = 1'b0;
    bus.Din = '0;
    bus.Drdy = 1'b0;
    tick();
    tick();
    chk("rst_dout", bus.Dout, '0);
    chk("rst_dvld", 128'(bus.Dvld), 128'(0));
    chk("rst_kvld", 128'(bus.Kvld), 128'(0));
    chk("rst_bsy", 128'(bus.BSY), 128'(0));
    rst_n = 1'b1;
    bus.Din = D1;
    bus.Drdy = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      busy_seen |= bus.BSY | bus.Dvld;
    end
    bus.Drdy = 1'b0;
    chk("nokey_drdy_ignored", 128'(busy_seen), 128'(0));
    bus.Kin = K1;
    bus.Krdy = 1'b1;
    tick();
    bus.Krdy = 1'b0;
    chk("kvld_pulse", 128'(bus.Kvld), 128'(1));
    tick();
    chk("kvld_single", 128'(bus.Kvld), 128'(0));
    run_block("v1", D1, C1, 1'b0);
    tick();
    chk("v1_dvld_single", 128'(bus.Dvld), 128'(0));
`ifdef AES_CTRL_MASK_DOUT_EN
    chk("v1_dout_masked_after", bus.Dout, '0);
`else
    chk("v1_dout_hold", bus.Dout, C1);
`endif
    bus.Kin = K2;
    bus.Krdy = 1'b1;
    bus.Din = D1;
    bus.Drdy = 1'b1;
    tick();
    bus.Krdy = 1'b0;
    bus.Drdy = 1'b0;
    chk("both_kvld", 128'(bus.Kvld), 128'(1));
    chk("both_no_bsy", 128'(bus.BSY), 128'(0));
    tick();
    chk("both_no_start", 128'(bus.BSY), 128'(0));
    run_block("v2", D2, C2, 1'b0);
    run_block("v2_b2b", D2, C2, 1'b0);
    tick();
    run_block("v2_poke", D2, C2, 1'b1);
    tick();
    bus.Din = D1;
    bus.Drdy = 1'b1;
    tick();
    bus.Drdy = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_dout", bus.Dout, '0);
    chk("abort_dvld", 128'(bus.Dvld), 128'(0));
    chk("abort_bsy", 128'(bus.BSY), 128'(0));
    chk("abort_kvld", 128'(bus.Kvld), 128'(0));
    tick();
    rst_n = 1'b1;
    bus.Din = D1;
    bus.Drdy = 1'b1;
    tick();
    bus.Drdy = 1'b0;
    chk("abort_nokey", 128'(bus.BSY), 128'(0));
    bus.Kin = K1;
    bus.Krdy = 1'b1;
    tick();
    bus.Krdy = 1'b0;
    chk("reload_kvld", 128'(bus.Kvld), 128'(1));
    run_block("v1_again", D1, C1, 1'b0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer around one combinational single-round core (AES_Core).
- Holds the state register, round-key register, round counter and Rcon.
- Computes the round keys on the fly and applies the final round without MixColumns (core sel=1) in round 10.
- Sits between the bus-side key/data loaders and the result consumer. One 128-bit block is in flight at a time.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, other values unsupported.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- Kin  in  128  cipher key, byte 0 at [127:120].
- Krdy  in  1  key-load strobe, sampled on CLK.
- Din  in  128  plaintext block.
- Drdy  in  1  data-load strobe, sampled on CLK.
- Dout  out  128  ciphertext block.
- Dvld  out  1  one-cycle pulse, Dout valid.
- Kvld  out  1  one-cycle pulse, key accepted.
- BSY  out  1  high while a block is being processed.

Behaviour:
- Clock/reset: one clock domain, CLK. RSTn is asynchronous and active-low. All registers clear on reset.
- Reset values:
  - Dout = 0, Dvld = 0, Kvld = 0, BSY = 0.
  - Key-loaded flag = 0, round counter = 0, Rcon = 8'h01, state and key registers = 0.
- FSM states: NOKEY, IDLE, RUN.
- NOKEY (after reset):
  - Drdy is ignored.
  - Krdy=1: K0 <= Kin, Kvld=1 next cycle, go to IDLE.
- IDLE:
  - Krdy=1: reload K0, Kvld pulse, stay in IDLE.
  - Drdy=1 with Krdy=0: state <= Din ^ K0, rk <= K0, Rcon <= 01, rnd <= 1, BSY <= 1, go to RUN.
  - Krdy and Drdy both high in the same cycle: the key load wins and Drdy is dropped (no Dvld for it).
- RUN, at each edge:
  - rk_next = keyexp(rk, Rcon).
  - state <= AES_Core(state, rk_next, sel = (rnd==NR)).
  - rk <= rk_next, Rcon <= xtime(Rcon), rnd <= rnd+1.
- Key expansion (keyexp):
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Uses four S-box byte lanes.
- Round 10 completion:
  - At the rnd==NR edge, Dout <= the round-10 output and Dvld <= 1 for exactly one cycle.
  - BSY <= 0 and the FSM returns to IDLE at the same edge; rnd <= 0.
- Latency: 11 edges from the accepting edge to Dvld high. Drdy is accepted at edge E0 and Dvld is high in the cycle after E10.
- Throughput: a new Drdy may be accepted in the same cycle Dvld is high, giving a back-to-back period of 11 cycles.
- Inputs during RUN: Krdy and Drdy are ignored, with no queuing. K0 is unchanged, so the next block uses the same key without a reload.
- Rcon arithmetic: xtime is a left shift with conditional ^8'h1b. The sequence is 01,02,04,08,10,20,40,80,1b,36.
- Reset mid-RUN: aborts immediately. No Dvld is issued, BSY=0, the FSM returns to NOKEY and the key must be reloaded.
- Dout holds the last result between blocks, unless the optional feature below is enabled.

Optional Feature:
- Macro: AES_CTRL_MASK_DOUT_EN.
- Defined: Dout is driven to 128'h0 in every cycle except the Dvld cycle. The result register is cleared on the edge after Dvld, so no ciphertext lingers on the bus.
- Undefined: Dout holds the last ciphertext until the next block completes or reset.

Test Plan:
- Vector 1 (FIPS-197 C.1): Krdy with Kin=000102030405060708090a0b0c0d0e0f, then Drdy with Din=00112233445566778899aabbccddeeff -> Kvld pulse one cycle later; Dvld 11 cycles after Drdy; Dout=69c4e0d86a7b0430d8cdb78070b4c55a.
- Vector 2 (FIPS-197 Appendix B): Kin=2b7e151628aed2a6abf7158809cf4f3c, Din=3243f6a8885a308d313198a2e0370734 -> Dout=3925841d02dc09fbdc118597196a0b32. Then Drdy again in the Dvld cycle with the same Din -> the same Dout 11 cycles later, with no key reload.
- Drdy with no key loaded after reset -> no BSY, no Dvld for 20 cycles.
- Drdy and Krdy in the same IDLE cycle -> Kvld only, no BSY. During RUN, pulse Krdy with a different key and Drdy -> both ignored; the result matches the original key.
- Deassert RSTn at round 5 -> all outputs 0 immediately, FSM in NOKEY. After reload, the vector 1 result is correct.
- With AES_CTRL_MASK_DOUT_EN: Dout=0 before and after the single Dvld cycle. Without it: Dout holds 69c4e0d8... after Dvld falls.
